// File: rtl/xyolo_weight_stage.sv
// xyolo_weight_stage
//   Fetches one layer slice (bias word followed by weight vectors) from external memory over a
//   read-only databus port, buffers the weight vectors internally and replays them, one vector
//   per cycle, as the lane-parallel weight flow for the xyolo array. The bias word is presented
//   statically on flow_out_bias.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   run / done        start pulse (sampled in IDLE) / high while IDLE
//   cfg_ext_addr      byte address of bus word 0
//   cfg_n_words       total bus words to fetch (word 0 = bias, words 1.. = weights)
//   cfg_w_iter        number of full replay passes over the weight buffer
//   databus_*         single-outstanding read request port (wdata/wstrb tied 0)
//   weight_valid      flow_out_weight carries a new vector this cycle
//   weight_last       last vector of each pass
//   flow_out_weight   weight vector, lane i = bits [DATAPATH_W*i +: DATAPATH_W]
//   flow_out_bias     bias vector, held from end of FETCH until the next fetch of word 0

module xyolo_weight_stage #(
    parameter int unsigned DATAPATH_W = 32,
    parameter int unsigned N_LANES    = 8,
    parameter int unsigned DATABUS_W  = 256,
    parameter int unsigned IO_ADDR_W  = 32,
    parameter int unsigned MEM_ADDR_W = 7,
    parameter int unsigned ITER_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    output logic                          done,
    input  logic [IO_ADDR_W-1:0]          cfg_ext_addr,
    input  logic [MEM_ADDR_W:0]           cfg_n_words,
    input  logic [ITER_W-1:0]             cfg_w_iter,
    input  logic                          databus_ready,
    output logic                          databus_valid,
    output logic [IO_ADDR_W-1:0]          databus_addr,
    input  logic [DATABUS_W-1:0]          databus_rdata,
    output logic [DATABUS_W-1:0]          databus_wdata,
    output logic [DATABUS_W/8-1:0]        databus_wstrb,
    output logic                          weight_valid,
    output logic                          weight_last,
    output logic [N_LANES*DATAPATH_W-1:0] flow_out_weight,
    output logic [N_LANES*DATAPATH_W-1:0] flow_out_bias
);

    localparam int unsigned VEC_W = N_LANES * DATAPATH_W;
    localparam int unsigned DEPTH = 2 ** MEM_ADDR_W;

    localparam logic [IO_ADDR_W-1:0]  WORD_BYTES = IO_ADDR_W'(DATABUS_W / 8);
    localparam logic [MEM_ADDR_W:0]   NW_ONE     = (MEM_ADDR_W + 1)'(1);
    localparam logic [MEM_ADDR_W:0]   NW_TWO     = (MEM_ADDR_W + 1)'(2);
    localparam logic [MEM_ADDR_W:0]   DEPTH_N    = (MEM_ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_ADDR_W-1:0] MA_ONE     = MEM_ADDR_W'(1);
    localparam logic [ITER_W-1:0]     IT_ONE     = ITER_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStream
    } state_e;

    state_e state_q, state_d;

    // Shadowed configuration
    logic [IO_ADDR_W-1:0]  ext_addr_q;
    logic [MEM_ADDR_W:0]   n_words_q;
    logic [ITER_W-1:0]     w_iter_q;

    // Fetch side
    logic [MEM_ADDR_W:0]   word_cnt_q;
    logic                  bus_valid_q;
    logic [IO_ADDR_W-1:0]  bus_addr_q;

    // Stream side: issue stage (address) then output stage (registered read data)
    logic [MEM_ADDR_W:0]   p_cnt_q;
    logic [ITER_W-1:0]     it_cnt_q;
    logic                  issue_end_q;
    logic                  rd_en_q;
    logic                  rd_last_q;
    logic [MEM_ADDR_W-1:0] rd_addr_q;

    logic [VEC_W-1:0]      weight_q;
    logic [VEC_W-1:0]      bias_q;
    logic                  weight_valid_q;
    logic                  weight_last_q;

    logic [VEC_W-1:0]      mem [DEPTH];

    logic                  bus_fire;
    logic                  last_word;
    logic [MEM_ADDR_W:0]   p_len;
    logic                  last_p;
    logic                  last_it;
    logic [MEM_ADDR_W-1:0] wr_addr;

    assign bus_fire  = bus_valid_q & databus_ready;
    assign last_word = (word_cnt_q == n_words_q - NW_ONE);
    // Pass length is the number of weight words, capped at the buffer depth.
    assign p_len     = (n_words_q - NW_ONE > DEPTH_N) ? DEPTH_N : (n_words_q - NW_ONE);
    assign last_p    = (p_cnt_q == p_len - NW_ONE);
    assign last_it   = (it_cnt_q == w_iter_q - IT_ONE);
    // Word k lands at (k-1) mod depth; the truncated subtraction gives the wrap for free.
    assign wr_addr   = word_cnt_q[MEM_ADDR_W-1:0] - MA_ONE;

    assign done            = (state_q == StIdle);
    assign databus_valid   = bus_valid_q;
    assign databus_addr    = bus_addr_q;
    assign databus_wdata   = '0;
    assign databus_wstrb   = '0;
    assign weight_valid    = weight_valid_q;
    assign weight_last     = weight_last_q;
    assign flow_out_weight = weight_q;
    assign flow_out_bias   = bias_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run && (cfg_n_words != '0)) state_d = StFetch;
            end
            StFetch: begin
                if (bus_fire && last_word) begin
                    state_d = ((n_words_q >= NW_TWO) && (w_iter_q != '0)) ? StStream : StIdle;
                end
            end
            StStream: begin
                // Leave once the final read has reached the output register, so the
                // last vector is on the flow in the first IDLE cycle.
                if (issue_end_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            ext_addr_q     <= '0;
            n_words_q      <= '0;
            w_iter_q       <= '0;
            word_cnt_q     <= '0;
            bus_valid_q    <= 1'b0;
            bus_addr_q     <= '0;
            p_cnt_q        <= '0;
            it_cnt_q       <= '0;
            issue_end_q    <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_last_q      <= 1'b0;
            rd_addr_q      <= '0;
            weight_q       <= '0;
            bias_q         <= '0;
            weight_valid_q <= 1'b0;
            weight_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        ext_addr_q  <= cfg_ext_addr;
                        n_words_q   <= cfg_n_words;
                        w_iter_q    <= cfg_w_iter;
                        word_cnt_q  <= '0;
                        p_cnt_q     <= '0;
                        it_cnt_q    <= '0;
                        issue_end_q <= 1'b0;
                        if (cfg_n_words != '0) begin
                            bus_valid_q <= 1'b1;
                            bus_addr_q  <= cfg_ext_addr;
                        end
                    end
                end
                StFetch: begin
                    if (bus_fire) begin
                        word_cnt_q <= word_cnt_q + NW_ONE;
                        if (word_cnt_q == '0) bias_q <= databus_rdata;
                        if (last_word) begin
                            bus_valid_q <= 1'b0;
                        end else begin
                            bus_addr_q <= bus_addr_q + WORD_BYTES;
                        end
                    end
                end
                StStream: begin
                    if (!issue_end_q) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= p_cnt_q[MEM_ADDR_W-1:0];
                        rd_last_q <= last_p;
                        if (last_p) begin
                            p_cnt_q <= '0;
                            if (last_it) begin
                                issue_end_q <= 1'b1;
                            end else begin
                                it_cnt_q <= it_cnt_q + IT_ONE;
                            end
                        end else begin
                            p_cnt_q <= p_cnt_q + NW_ONE;
                        end
                    end
                end
                default: ;
            endcase

            weight_valid_q <= rd_en_q;
            weight_last_q  <= rd_en_q & rd_last_q;
            if (rd_en_q) weight_q <= mem[rd_addr_q];
        end
    end

    // Buffer has no reset; contents are only read after being written in the same run.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StFetch) && bus_fire && (word_cnt_q != '0)) begin
            mem[wr_addr] <= databus_rdata;
        end
    end

endmodule

// File: tb/tb_xyolo_weight_stage.sv
// Bench for xyolo_weight_stage with a 4-deep buffer so depth wrap is reachable.
// A bus responder serves address-derived data; a list-based model predicts the request
// addresses, bias and weight stream of each run.

module tb_xyolo_weight_stage;

    localparam int DW = 32;
    localparam int NL = 8;
    localparam int BW = 256;
    localparam int AW = 32;
    localparam int MW = 2;
    localparam int IW = 16;
    localparam int DEPTH = 4;
    localparam int BUDGET = 400;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           done;
    logic [AW-1:0]  cfg_ext_addr;
    logic [MW:0]    cfg_n_words;
    logic [IW-1:0]  cfg_w_iter;
    logic           databus_ready;
    logic           databus_valid;
    logic [AW-1:0]  databus_addr;
    logic [BW-1:0]  databus_rdata;
    logic [BW-1:0]  databus_wdata;
    logic [BW/8-1:0] databus_wstrb;
    logic           weight_valid;
    logic           weight_last;
    logic [NL*DW-1:0] flow_out_weight;
    logic [NL*DW-1:0] flow_out_bias;

    xyolo_weight_stage #(
        .DATAPATH_W (DW),
        .N_LANES    (NL),
        .DATABUS_W  (BW),
        .IO_ADDR_W  (AW),
        .MEM_ADDR_W (MW),
        .ITER_W     (IW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .done            (done),
        .cfg_ext_addr    (cfg_ext_addr),
        .cfg_n_words     (cfg_n_words),
        .cfg_w_iter      (cfg_w_iter),
        .databus_ready   (databus_ready),
        .databus_valid   (databus_valid),
        .databus_addr    (databus_addr),
        .databus_rdata   (databus_rdata),
        .databus_wdata   (databus_wdata),
        .databus_wstrb   (databus_wstrb),
        .weight_valid    (weight_valid),
        .weight_last     (weight_last),
        .flow_out_weight (flow_out_weight),
        .flow_out_bias   (flow_out_bias)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ext;
        int          n;
        int          iter;
        int          rmode;     // 0 ready always, 1 every 3rd cycle, 2 random
        bit          usek;      // data word k = {8{k}} instead of hashed data
        bit          poke;      // pulse run during the stream
        int          exp_fetch;
        int          exp_wv;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          use_k;
    int          rmode;
    logic [31:0] ext_cur;
    logic [31:0] salt;
    logic [BW-1:0] model_bias;
    logic [BW-1:0] model_weight;
    logic [BW-1:0] buf_m [DEPTH];

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [BW:0] got, input logic [BW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [BW-1:0] word_data(input logic [31:0] a);
        logic [BW-1:0] v;
        logic [31:0]   k;
        k = (a - ext_cur) >> 5;
        for (int i = 0; i < NL; i++) begin
            v[32*i +: 32] = use_k ? k : ((a * 32'd7 + 32'(i) * 32'h0101_0101) ^ salt);
        end
        return v;
    endfunction

    function automatic logic ready_now();
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return (cyc % 3 == 2);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_bias   = '0;
        model_weight = '0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] exp_addr[$];
        logic [31:0] got_addr[$];
        logic [BW:0] exp_w[$];
        logic [BW:0] got_w[$];
        int          p_len;
        int          c;
        int          last_fire;
        int          first_wv;
        int          last_wv;
        int          unstable;
        bit          pv;
        bit          pr;
        logic [31:0] pa;
        bit          poked;
        bit          rise_wv;
        bit          timed_out;

        ext_cur = v.ext;
        use_k   = v.usek;
        rmode   = v.rmode;
        salt    = $urandom;

        // Reference: addresses, bias, buffer image and replayed stream
        for (int k = 0; k < v.n; k++) exp_addr.push_back(v.ext + 32'(32 * k));
        if (v.n > 0) model_bias = word_data(v.ext);
        for (int k = 1; k < v.n; k++) buf_m[(k - 1) % DEPTH] = word_data(v.ext + 32'(32 * k));
        p_len = (v.n - 1 > DEPTH) ? DEPTH : v.n - 1;
        if (v.n >= 2 && v.iter > 0) begin
            for (int it = 0; it < v.iter; it++) begin
                for (int p = 0; p < p_len; p++) exp_w.push_back({p == p_len - 1, buf_m[p]});
            end
        end

        cfg_ext_addr  = v.ext;
        cfg_n_words   = 3'(v.n);
        cfg_w_iter    = 16'(v.iter);
        run           = 1'b1;
        databus_ready = ready_now();
        databus_rdata = {8{$urandom}};
        step();
        c = 1;
        last_fire = -100;
        first_wv = -1;
        last_wv = -1;
        unstable = 0;
        pv = 0;
        pr = 0;
        pa = '0;
        poked = 0;
        rise_wv = 0;
        timed_out = 0;
        check_int({tag, " done after run"}, int'(done), int'(v.n == 0));

        while (1) begin
            run          = 1'b0;
            cfg_ext_addr = v.ext;
            cfg_n_words  = 3'(v.n);
            cfg_w_iter   = 16'(v.iter);
            if (c > BUDGET) begin
                timed_out = 1;
                break;
            end
            if (databus_valid && pv && !pr && databus_addr !== pa) unstable++;
            if (weight_valid) begin
                if (first_wv < 0) first_wv = c;
                last_wv = c;
                got_w.push_back({weight_last, flow_out_weight});
                if (v.poke && !poked) begin
                    run          = 1'b1;
                    cfg_ext_addr = $urandom;
                    cfg_n_words  = 3'd7;
                    cfg_w_iter   = 16'd1;
                    poked        = 1;
                end
            end
            if (done) begin
                rise_wv = weight_valid;
                break;
            end
            databus_ready = ready_now();
            databus_rdata = databus_valid ? word_data(databus_addr) : {8{$urandom}};
            if (databus_valid && databus_ready) begin
                got_addr.push_back(databus_addr);
                last_fire = c;
            end
            pv = databus_valid;
            pr = databus_ready;
            pa = databus_addr;
            step();
            c++;
        end

        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", tag, BUDGET);
            do_reset();
            return;
        end

        check_int({tag, " fetch count"}, got_addr.size(), v.exp_fetch);
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check_vec($sformatf("%s addr[%0d]", tag, i), {225'd0, got_addr[i]},
                      {225'd0, exp_addr[i]});
        end
        check_int({tag, " addr stable"}, unstable, 0);
        check_vec({tag, " bias"}, {1'b0, flow_out_bias}, {1'b0, model_bias});
        check_int({tag, " weight count"}, got_w.size(), v.exp_wv);
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            check_vec($sformatf("%s weight[%0d]", tag, i), got_w[i], exp_w[i]);
        end
        if (exp_w.size() > 0) begin
            check_int({tag, " first weight latency"}, first_wv - last_fire, 3);
            check_int({tag, " stream contiguous"}, last_wv - first_wv + 1, got_w.size());
            check_int({tag, " final vector with done"}, int'(rise_wv), 1);
            model_weight = exp_w[exp_w.size() - 1][BW-1:0];
        end

        for (int i = 0; i < 2; i++) begin
            databus_ready = ready_now();
            step();
            check_int({tag, " idle no bus"}, int'(databus_valid), 0);
            check_int({tag, " idle no weight"}, int'(weight_valid), 0);
        end
        check_vec({tag, " weight held"}, {1'b0, flow_out_weight}, {1'b0, model_weight});
    endtask

    vec_t tbl[7];

    initial begin
        vec_t r;
        int   n;
        int   it;

        tbl[0] = '{32'h0000_1000, 4, 2, 0, 1'b1, 1'b0, 4, 6};   // basic
        tbl[1] = '{32'h0000_1000, 4, 2, 1, 1'b1, 1'b0, 4, 6};   // backpressure
        tbl[2] = '{32'h0000_2000, 0, 3, 0, 1'b0, 1'b0, 0, 0};   // no words
        tbl[3] = '{32'h0000_3000, 1, 5, 2, 1'b0, 1'b0, 1, 0};   // bias only
        tbl[4] = '{32'h0000_4000, 3, 0, 0, 1'b0, 1'b0, 3, 0};   // zero iterations
        tbl[5] = '{32'h0000_5000, 6, 1, 0, 1'b1, 1'b0, 6, 4};   // depth wrap: 5,2,3,4
        tbl[6] = '{32'h0000_8000, 4, 3, 2, 1'b0, 1'b1, 4, 9};   // run during stream

        rst           = 1'b1;
        run           = 1'b1;
        cfg_ext_addr  = 32'h0000_1000;
        cfg_n_words   = 3'd4;
        cfg_w_iter    = 16'd2;
        databus_ready = 1'b0;
        databus_rdata = '0;
        ext_cur       = '0;
        use_k         = 0;
        rmode         = 0;
        salt          = '0;
        step();
        step();
        check_int("reset done", int'(done), 1);
        check_int("reset bus valid", int'(databus_valid), 0);
        check_vec("reset bus addr", {225'd0, databus_addr}, '0);
        check_int("reset weight valid", int'(weight_valid), 0);
        check_int("reset weight last", int'(weight_last), 0);
        check_vec("reset weight", {1'b0, flow_out_weight}, '0);
        check_vec("reset bias", {1'b0, flow_out_bias}, '0);
        rst = 1'b0;
        run = 1'b0;
        model_bias   = '0;
        model_weight = '0;
        step();
        check_int("post reset bus valid", int'(databus_valid), 0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a request is outstanding; late ready must be ignored
        cfg_ext_addr  = 32'h0000_7000;
        cfg_n_words   = 3'd5;
        cfg_w_iter    = 16'd1;
        databus_ready = 1'b0;
        run           = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        check_int("abort req valid", int'(databus_valid), 1);
        check_vec("abort req addr", {225'd0, databus_addr}, {225'd0, 32'h0000_7000});
        databus_ready = 1'b1;
        databus_rdata = {8{32'hdead_beef}};
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_bias   = '0;
        model_weight = '0;
        check_int("abort valid dropped", int'(databus_valid), 0);
        check_int("abort done", int'(done), 1);
        step();
        step();
        check_int("late ready ignored", int'(databus_valid), 0);
        check_vec("late ready bias", {1'b0, flow_out_bias}, '0);
        run_txn('{32'h0000_7000, 5, 1, 0, 1'b0, 1'b0, 5, 4}, "restart");

        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 7);
            it = $urandom_range(0, 4);
            r  = '{$urandom, n, it, $urandom_range(0, 2), 1'b0, 1'b0, n,
                   (n >= 2) ? ((n - 1 > DEPTH) ? DEPTH : n - 1) * it : 0};
            run_txn(r, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
